// File: rtl/mmio_router.sv
// Data-port router: maps CPU accesses onto N device regions via a registered
// req/ack handshake with timeout, or passes them through to the default target.
module mmio_router #(
    parameter int N_DEV = 4,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int SEL_W = 4,
    parameter logic [N_DEV*SEL_W-1:0] DEV_SEL = {4'hf, 4'he, 4'hd, 4'hc},
    parameter int TIMEOUT = 255,
    parameter int TO_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic                    cpu_read,
    input  logic                    cpu_write,
    input  logic [DATA_W-1:0]       cpu_wdata,
    input  logic [DATA_W/8-1:0]     cpu_ben,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_stall,
    output logic                    dflt_read,
    output logic                    dflt_write,
    input  logic [DATA_W-1:0]       dflt_rdata,
    input  logic                    dflt_stall,
    output logic [N_DEV-1:0]        dev_req,
    output logic                    dev_we,
    output logic [ADDR_W-1:0]       dev_addr,
    output logic [DATA_W-1:0]       dev_wdata,
    output logic [DATA_W/8-1:0]     dev_ben,
    input  logic [N_DEV-1:0]        dev_ack,
    input  logic [N_DEV*DATA_W-1:0] dev_rdata,
    output logic                    bus_err,
    output logic [ADDR_W-1:0]       err_addr,
    input  logic                    err_clr
);

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t nxt;

    logic [SEL_W-1:0]  sel;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [IDX_W-1:0]  idx_q;
    logic [TO_W-1:0]   cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              active;
    logic              go;
    logic              ack;
    logic              last;
    logic              to_err;

    assign sel = cpu_addr[ADDR_W-1 -: SEL_W];
    assign active = cpu_read | cpu_write;
    assign go = active & hit;
    assign ack = dev_ack[idx_q];
    assign last = (cnt == TO_LAST);
    assign to_err = (state == BUSY) & ~ack & last;

    // Scan downwards so the lowest matching index is the one that sticks.
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (sel == DEV_SEL[i*SEL_W +: SEL_W]) begin
                hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (go) nxt = BUSY;
            BUSY: begin
                if (ack) begin
                    nxt = DONE;
                end else if (last) begin
                    nxt = ERR;
                end
            end
            DONE: nxt = IDLE;
            ERR:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            dev_req <= '0;
            dev_we <= 1'b0;
            dev_addr <= '0;
            dev_wdata <= '0;
            dev_ben <= '0;
            cnt <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        idx_q <= hit_idx;
                        dev_req <= N_DEV'(1) << hit_idx;
                        dev_we <= cpu_write;
                        dev_addr <= cpu_addr;
                        dev_wdata <= cpu_wdata;
                        dev_ben <= cpu_ben;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (ack) begin
                        rdata_q <= dev_rdata[idx_q*DATA_W +: DATA_W];
                        dev_req <= '0;
                    end else if (last) begin
                        rdata_q <= '0;
                        dev_req <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A fresh timeout beats a concurrent clear; only the first address is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err <= 1'b0;
            err_addr <= '0;
        end else if (to_err) begin
            bus_err <= 1'b1;
            if (!bus_err) err_addr <= dev_addr;
        end else if (err_clr) begin
            bus_err <= 1'b0;
        end
    end

    always_comb begin
        dflt_read = cpu_read & ~hit;
        dflt_write = cpu_write & ~hit;
        cpu_stall = dflt_stall;
        cpu_rdata = dflt_rdata;
        if (hit) begin
            cpu_stall = active & ((state == IDLE) | (state == BUSY));
            cpu_rdata = ((state == DONE) | (state == ERR)) ? rdata_q : '0;
        end
    end

endmodule

// File: doc/mmio_router.md
Name: mmio_router

Overview:
- Parametrised data-port router between the CPU memory stage and N memory-mapped devices (text memory, timer, keyboard, loader, ...).
- Each device region is selected by the top SEL_W bits of the word address.
- A matching access becomes a registered req/ack transaction with a per-access timeout; the CPU is stalled until ack.
- Non-matching accesses pass straight through to the default target (cache manage unit).
- Replaces the fixed 3-count write stall with a general handshake, and adds bus-error reporting.

Parameters:
N_DEV, 4, number of device regions (1..8)
ADDR_W, 30, CPU word-address width
DATA_W, 32, data width
SEL_W, 4, number of top address bits compared for region select
DEV_SEL, {4'hf,4'he,4'hd,4'hc}, packed N_DEV*SEL_W select codes; entry i is bits [i*SEL_W +: SEL_W]
TIMEOUT, 255, BUSY cycles without ack before error (1..2**TO_W-1)
TO_W, 8, timeout counter width

Ports:
clk  in  1  clock; CPU pipeline advances on every clk edge with cpu_stall low
rst  in  1  asynchronous reset, active-low
cpu_addr  in  ADDR_W  word address
cpu_read  in  1  read request
cpu_write  in  1  write request
cpu_wdata  in  DATA_W  store data
cpu_ben  in  DATA_W/8  byte write enables
cpu_rdata  out  DATA_W  load data
cpu_stall  out  1  stall to pipeline
dflt_read  out  1  read to default target
dflt_write  out  1  write to default target
dflt_rdata  in  DATA_W  default target read data
dflt_stall  in  1  default target stall
dev_req  out  N_DEV  one-hot request, registered
dev_we  out  1  registered write flag
dev_addr  out  ADDR_W  registered address
dev_wdata  out  DATA_W  registered store data
dev_ben  out  DATA_W/8  registered byte enables
dev_ack  in  N_DEV  per-device completion, one cycle
dev_rdata  in  N_DEV*DATA_W  per-device read data, valid with ack
bus_err  out  1  sticky timeout flag
err_addr  out  ADDR_W  address of the first timed-out access
err_clr  in  1  clears bus_err

Behaviour:
- Decode is combinational. hit_i = cpu_addr[ADDR_W-1 -: SEL_W] == DEV_SEL[i]. If several entries match, the lowest index wins. active = cpu_read|cpu_write.
- No hit:
  - dflt_read/dflt_write = cpu_read/cpu_write.
  - cpu_rdata = dflt_rdata; cpu_stall = dflt_stall.
  - Router FSM unaffected.
- Hit: dflt_read and dflt_write are 0.
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE:
  - Transition: if active & hit, latch idx, addr, wdata, ben, we=cpu_write into the dev_* registers; set dev_req[idx]; clear counter; go to BUSY.
  - Request latency: dev_req rises 1 cycle after the access is presented.
- BUSY:
  - dev_req[idx] held high and dev_* held stable; counter increments each cycle.
  - dev_ack[idx]=1: capture dev_rdata[idx] into rdata_q; drop dev_req; go to DONE.
  - Else if counter == TIMEOUT-1: drop dev_req; rdata_q=0; go to ERR.
  - Ack in the same cycle as timeout: ack wins.
  - Acks on other indices are ignored.
- DONE and ERR:
  - Last exactly one cycle; cpu_stall=0 and cpu_rdata=rdata_q; then go to IDLE unconditionally.
  - The pipeline consumes the access on that edge.
  - Back-to-back identical accesses are therefore two transactions.
- ERR entry:
  - bus_err <= 1.
  - err_addr latched only if bus_err was 0, so the first error is kept.
- err_clr: bus_err <= 0 on the next edge. err_clr and a new error in the same cycle: error wins.
- Stall rule: cpu_stall = active & hit & (state is IDLE or BUSY).
  - Minimum device access costs 2 stall cycles (IDLE, BUSY with same-cycle ack), then DONE.
- cpu_rdata during a hit stall is 0.
- Reset values: dev_req=0, dev_we=0, dev_addr/wdata/ben=0, rdata_q=0, bus_err=0, err_addr=0, state=IDLE, counter=0.
- Reset mid-BUSY drops dev_req immediately (asynchronously). A late ack after reset is ignored.
- Counter must not wrap: TIMEOUT must be <= 2**TO_W-1.

Test Plan:
1. Write 0x41, ben 4'b0001, to addr 30'h3000_0010 (sel c, dev0), dev0 ack 1 cycle after req -> dev_req=4'b0001 for 2 cycles with dev_addr/dev_wdata stable; cpu_stall high 3 cycles, low in DONE; one transaction only.
2. Read 30'h3C00_0004 (sel f, dev3), ack with dev_rdata[3]=32'h1234_5678 -> cpu_rdata=32'h1234_5678 in the DONE cycle; dflt_read stays 0.
3. Read addr 30'h0000_0100 (no hit), dflt_stall toggled -> cpu_stall mirrors dflt_stall; cpu_rdata=dflt_rdata; dev_req stays 0.
4. Dev2 (sel e) never acks, TIMEOUT=255 -> req drops after 255 BUSY cycles; ERR cycle with cpu_rdata=0 and stall low; bus_err=1, err_addr=access addr. A second timeout keeps the first err_addr. err_clr -> bus_err=0.
5. Two consecutive identical stores to dev0 -> two separate req/ack transactions.
6. rst low during BUSY -> dev_req=0 and bus_err=0 immediately; an ack arriving after reset release has no effect; state IDLE.
